supersaw_voice_alloc: RTL and testbench

SUPERSAW_VOICE_ALLOC -- requirements
Module: supersaw_voice_alloc

---
 rtl/supersaw_pkg.sv | 13 +
 rtl/supersaw_voice_slot.sv | 36 +++
 rtl/supersaw_voice_alloc.sv | 162 ++++++++++++++++
 tb/tb_supersaw_voice_alloc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/supersaw_pkg.sv
// Shared sizing defaults and FSM encoding for the supersaw voice allocator.
package supersaw_pkg;
  localparam int NUM_VOICES_DEF = 4;
  localparam int PITCH_W_DEF    = 16;
  localparam int NOTE_W_DEF     = 7;
  localparam int AGE_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;
endpackage

// File: rtl/supersaw_voice_slot.sv
// One voice: gate, note, pitch and a saturating age counter.
module supersaw_voice_slot #(
  parameter int PITCH_W = supersaw_pkg::PITCH_W_DEF,
  parameter int NOTE_W  = supersaw_pkg::NOTE_W_DEF,
  parameter int AGE_W   = supersaw_pkg::AGE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic               clr,
  input  logic               age_inc,
  input  logic [NOTE_W-1:0]  ld_note,
  input  logic [PITCH_W-1:0] ld_pitch,
  output logic               gate,
  output logic [NOTE_W-1:0]  note,
  output logic [PITCH_W-1:0] pitch,
  output logic [AGE_W-1:0]   age
);
  always_ff @(posedge clk) begin
    if (rst) begin
      gate  <= 1'b0;
      note  <= '0;
      pitch <= '0;
      age   <= '0;
    end else if (ld) begin
      gate  <= 1'b1;
      note  <= ld_note;
      pitch <= ld_pitch;
      age   <= '0;
    end else begin
      // Release keeps note and pitch so the oscillator tail stays in tune.
      if (clr) gate <= 1'b0;
      if (age_inc && gate && (age != '1)) age <= age + 1'b1;
    end
  end
endmodule

// File: rtl/supersaw_voice_alloc.sv
// Voice allocator: serial scan over the voice slots, then a single commit cycle.
module supersaw_voice_alloc
  import supersaw_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PITCH_W    = PITCH_W_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_on,
  input  logic [NOTE_W-1:0]             req_note,
  input  logic [PITCH_W-1:0]            req_pitch,
  output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic                          done,
  output logic [$clog2(NUM_VOICES)-1:0] done_voice,
  output logic                          done_hit,
  output logic                          done_steal
);
  localparam int IDX_W = $clog2(NUM_VOICES);

  state_e state, state_nxt;

  logic [NUM_VOICES-1:0]              gate_a, ld_a, clr_a, inc_a;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]  note_a;
  logic [NUM_VOICES-1:0][PITCH_W-1:0] pitch_a;
  logic [NUM_VOICES-1:0][AGE_W-1:0]   age_a;

  logic [IDX_W-1:0]   scan_idx, match_idx, free_idx, steal_idx, sel_idx;
  logic               match_f, free_f, steal_f, sel_hit, sel_steal;
  logic [AGE_W-1:0]   steal_age;
  logic               r_on;
  logic [NOTE_W-1:0]  r_note;
  logic [PITCH_W-1:0] r_pitch;

  logic               cur_gate;
  logic [NOTE_W-1:0]  cur_note;
  logic [AGE_W-1:0]   cur_age;

  assign cur_gate    = gate_a[scan_idx];
  assign cur_note    = note_a[scan_idx];
  assign cur_age     = age_a[scan_idx];
  assign voice_pitch = pitch_a;
  assign voice_gate  = gate_a;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    done       = 1'b0;
    done_voice = '0;
    done_hit   = 1'b0;
    done_steal = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN:
        if (scan_idx == IDX_W'(NUM_VOICES - 1)) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        state_nxt  = ST_IDLE;
        done       = 1'b1;
        done_voice = sel_idx;
        done_hit   = sel_hit;
        done_steal = sel_steal;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Priority: retrigger, then free voice, then oldest gated voice.
  always_comb begin
    sel_idx   = '0;
    sel_hit   = 1'b0;
    sel_steal = 1'b0;
    if (r_on) begin
      sel_hit = 1'b1;
      if (match_f)     sel_idx = match_idx;
      else if (free_f) sel_idx = free_idx;
      else begin
        sel_idx   = steal_idx;
        sel_steal = 1'b1;
      end
    end else if (match_f) begin
      sel_idx = match_idx;
      sel_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx  <= '0;
      match_f   <= 1'b0;
      free_f    <= 1'b0;
      steal_f   <= 1'b0;
      match_idx <= '0;
      free_idx  <= '0;
      steal_idx <= '0;
      steal_age <= '0;
      r_on      <= 1'b0;
      r_note    <= '0;
      r_pitch   <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      r_on     <= req_on;
      r_note   <= req_note;
      r_pitch  <= req_pitch;
      scan_idx <= '0;
      match_f  <= 1'b0;
      free_f   <= 1'b0;
      steal_f  <= 1'b0;
    end else if (state == ST_SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (cur_gate && cur_note == r_note && !match_f) begin
        match_f   <= 1'b1;
        match_idx <= scan_idx;
      end
      if (!cur_gate && !free_f) begin
        free_f   <= 1'b1;
        free_idx <= scan_idx;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (cur_gate && (!steal_f || cur_age > steal_age)) begin
        steal_f   <= 1'b1;
        steal_idx <= scan_idx;
        steal_age <= cur_age;
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    assign ld_a[i]  = (state == ST_COMMIT) && r_on && (sel_idx == IDX_W'(i));
    assign clr_a[i] = (state == ST_COMMIT) && !r_on && sel_hit && (sel_idx == IDX_W'(i));
    assign inc_a[i] = (state == ST_COMMIT) && r_on && (sel_idx != IDX_W'(i));

    supersaw_voice_slot #(
      .PITCH_W (PITCH_W),
      .NOTE_W  (NOTE_W),
      .AGE_W   (AGE_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld_a[i]),
      .clr      (clr_a[i]),
      .age_inc  (inc_a[i]),
      .ld_note  (r_note),
      .ld_pitch (r_pitch),
      .gate     (gate_a[i]),
      .note     (note_a[i]),
      .pitch    (pitch_a[i]),
      .age      (age_a[i])
    );
  end
endmodule

// File: tb/tb_supersaw_voice_alloc.sv
// Scoreboard bench: stimulus pushes expected commits, a negedge monitor checks them.
module tb_supersaw_voice_alloc;
  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_on = 1'b0;
  logic [6:0]  req_note = '0;
  logic [15:0] req_pitch = '0;
  logic        req_ready;
  logic [63:0] voice_pitch;
  logic [3:0]  voice_gate;
  logic        done;
  logic [1:0]  done_voice;
  logic        done_hit;
  logic        done_steal;

  supersaw_voice_alloc dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_on      (req_on),
    .req_note    (req_note),
    .req_pitch   (req_pitch),
    .voice_pitch (voice_pitch),
    .voice_gate  (voice_gate),
    .done        (done),
    .done_voice  (done_voice),
    .done_hit    (done_hit),
    .done_steal  (done_steal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  v;
    logic        hit;
    logic        steal;
    logic [3:0]  gate;
    logic [63:0] pitch;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   chk_out = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_out) begin
      chk_out = 1'b0;
      chk("gate", 64'(voice_gate), 64'(pend.gate));
      chk("pitch", voice_pitch, pend.pitch);
      chk("done_cleared", 64'({done, done_hit, done_steal, done_voice}), 64'd0);
    end
    if (done === 1'b1) begin
      if (q.size() == 0) flag("unexpected_done");
      else begin
        pend = q.pop_front();
        chk("latency", 64'(cyc), 64'(pend.cyc));
        chk("done_voice", 64'(done_voice), 64'(pend.v));
        chk("done_hit", 64'(done_hit), 64'(pend.hit));
        chk("done_steal", 64'(done_steal), 64'(pend.steal));
        chk_out = 1'b1;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_ready !== 1'b1) flag("ready_timeout");
  endtask

  task automatic send(input bit on, input logic [6:0] note, input logic [15:0] pitch,
                      input logic [1:0] ev, input bit eh, input bit es,
                      input logic [3:0] eg, input logic [63:0] ep);
    exp_t e;
    int t = 0;
    wait_ready();
    req_valid = 1'b1;
    req_on    = on;
    req_note  = note;
    req_pitch = pitch;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.cyc = cyc + NV;
    e.v = ev; e.hit = eh; e.steal = es; e.gate = eg; e.pitch = ep;
    q.push_back(e);
    while (q.size() != 0 && t < NV + 20) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      flag("done_timeout");
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_gate", 64'(voice_gate), 64'd0);
    chk("rst_pitch", voice_pitch, 64'd0);
    chk("rst_done", 64'({done, done_hit, done_steal, done_voice}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
  endtask

  initial begin
    do_reset();
    // Fill all four voices, then steal, release, miss, retrigger, refill, steal again.
    send(1, 7'd60, 16'h1000, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_1000);
    send(1, 7'd62, 16'h1100, 2'd1, 1, 0, 4'b0011, 64'h0000_0000_1100_1000);
    send(1, 7'd64, 16'h1200, 2'd2, 1, 0, 4'b0111, 64'h0000_1200_1100_1000);
    send(1, 7'd65, 16'h1300, 2'd3, 1, 0, 4'b1111, 64'h1300_1200_1100_1000);
    send(1, 7'd67, 16'h2000, 2'd0, 1, 1, 4'b1111, 64'h1300_1200_1100_2000);
    send(0, 7'd64, 16'hdead, 2'd2, 1, 0, 4'b1011, 64'h1300_1200_1100_2000);
    send(0, 7'd70, 16'h0000, 2'd0, 0, 0, 4'b1011, 64'h1300_1200_1100_2000);
    send(1, 7'd62, 16'h3000, 2'd1, 1, 0, 4'b1011, 64'h1300_1200_3000_2000);
    send(1, 7'd71, 16'h3100, 2'd2, 1, 0, 4'b1111, 64'h1300_3100_3000_2000);
    send(1, 7'd72, 16'h3200, 2'd3, 1, 1, 4'b1111, 64'h3200_3100_3000_2000);

    // Retrigger of the same note.
    do_reset();
    send(1, 7'd60, 16'h1000, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_1000);
    send(1, 7'd60, 16'h1500, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_1500);

    // Note-off keeps the pitch; a miss changes nothing.
    do_reset();
    send(1, 7'd60, 16'h1000, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_1000);
    send(1, 7'd62, 16'h1100, 2'd1, 1, 0, 4'b0011, 64'h0000_0000_1100_1000);
    send(0, 7'd60, 16'h0000, 2'd0, 1, 0, 4'b0010, 64'h0000_0000_1100_1000);
    send(0, 7'd70, 16'h0000, 2'd0, 0, 0, 4'b0010, 64'h0000_0000_1100_1000);

    // Reset in the middle of a scan abandons the request.
    do_reset();
    send(1, 7'd50, 16'h0500, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_0500);
    wait_ready();
    req_valid = 1'b1;
    req_on    = 1'b1;
    req_note  = 7'd60;
    req_pitch = 16'h1000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("abort_gate", 64'(voice_gate), 64'd0);
    chk("abort_pitch", voice_pitch, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    repeat (NV + 3) @(negedge clk);
    chk("abort_gate_quiet", 64'(voice_gate), 64'd0);
    send(1, 7'd61, 16'h0610, 2'd0, 1, 0, 4'b0001, 64'h0000_0000_0000_0610);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
